apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- Round-robin arbiter and sequencer that shares one APB (APB4: pprot, pstrb) master port between PORTS simple request/response clients.
- Each client issues single-word read/write requests. The block drives the SETUP/ACCESS phases, waits on pready, and returns rdata/pslverr to the winning client.
- An optional timeout aborts a transfer when the completer hangs.
- Sits between CSR-issuing logic (DMA descriptors, management cores) and an APB interconnect.

Parameters:
- PORTS, 2, number of requesters (1..8).
- DATA_W, 32, APB data width (8/16/32).
- ADDR_W, 16, APB address width.
- STRB_W, DATA_W/8, byte strobe width.
- TIMEOUT, 256, ACCESS-phase cycles without pready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_req_valid  in  PORTS  per-port request valid.
- s_req_ready  out  PORTS  per-port request accept; one-hot or zero.
- s_req_addr  in  PORTS*ADDR_W  packed per-port address; port i at [i*ADDR_W +: ADDR_W].
- s_req_write  in  PORTS  1 = write.
- s_req_wdata  in  PORTS*DATA_W  packed write data.
- s_req_strb  in  PORTS*STRB_W  packed byte strobes.
- s_req_prot  in  PORTS*3  packed pprot.
- s_rsp_valid  out  PORTS  one-cycle response pulse to the originating port.
- s_rsp_rdata  out  DATA_W  read data; shared, qualified by s_rsp_valid.
- s_rsp_err  out  1  pslverr or timeout; shared, qualified by s_rsp_valid.
- m_apb_paddr  out  ADDR_W
- m_apb_pprot  out  3
- m_apb_psel  out  1
- m_apb_penable  out  1
- m_apb_pwrite  out  1
- m_apb_pwdata  out  DATA_W
- m_apb_pstrb  out  STRB_W
- m_apb_pready  in  1
- m_apb_prdata  in  DATA_W
- m_apb_pslverr  in  1

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer favours port 0.
  - All outputs 0: psel, penable, paddr, pwrite, pwdata, pstrb, pprot, s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err.
- States IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any s_req_valid is high, the winner is the first set bit at or after (last_grant+1) mod PORTS.
  - s_req_ready[winner] is driven combinationally high in this cycle only.
  - On the clock edge: capture the request fields into the m_apb_* registers, assert psel, record the grant, go to SETUP.
  - With no valid, all outputs hold their idle values.
- SETUP (1 cycle): psel=1, penable=0. Next edge: penable=1, go to ACCESS.
- ACCESS:
  - psel=1, penable=1; address and control held stable.
  - On pready=1: register prdata (forced to 0 for writes) and pslverr. Pulse s_rsp_valid[grant] for the next cycle. Drop psel and penable. Return to IDLE.
- Reads drive pwdata=0 and pstrb=0 (APB4 rule). Writes pass the captured strb unchanged; strb=0 is legal.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to ACCESS and increments each ACCESS cycle while pready=0.
  - After TIMEOUT such cycles with no pready, end the transfer as if pready had arrived, but with s_rsp_err=1 and rdata=0.
  - pready arriving in the same cycle the counter expires wins: normal completion, pslverr honoured.
- Latency and throughput:
  - Request accept edge to s_rsp_valid with zero-wait pready: 3 cycles.
  - The response cycle is an IDLE cycle, so a new request can be accepted during the response pulse. Peak throughput is 1 transfer / 3 cycles.
  - Each wait state adds 1 cycle.
- Responses have no backpressure. Clients must accept s_rsp_valid when it pulses.
- Fairness: last_grant updates only on acceptance. With all ports requesting continuously, grants rotate 0,1,..,PORTS-1.
- Request inputs are sampled only on the accept edge; changes afterward have no effect.
- Reset mid-transfer: psel and penable deassert immediately (asynchronously). No response is issued for the aborted transfer. The pointer returns to port 0.

Decomposition:
- Shared package/header: state encodings (IDLE=0, SETUP=1, ACCESS=2), timeout counter width $clog2(TIMEOUT+1), APB pprot bit constants.
- One sub-module: apb_rr_arb, a PORTS-wide round-robin arbiter.
  - Inputs: req, update enable.
  - Outputs: one-hot grant, encoded index.
  - The grant is combinational; the pointer is registered.

Test Plan:
- Port 0 write addr 0x0010, data 0xDEADBEEF, strb 0xF, prot 3'b010, pready tied 1:
  - psel rises 1 cycle after accept; penable rises 1 cycle later.
  - Completer sees the write; s_rsp_valid[0] pulses 3 cycles after accept with err=0.
- Port 1 read 0x0020, completer returns 0x12345678 after 2 wait states:
  - pstrb=0 and pwdata=0 throughout.
  - s_rsp_rdata=0x12345678 with s_rsp_valid[1] on accept+5.
- Both ports request 4 transfers each simultaneously:
  - Grant order 0,1,0,1,...; accepts spaced exactly 3 cycles apart.
  - Each response pulses only on the originating port.
- Completer asserts pslverr with pready on a write to 0x00FF -> s_rsp_err=1, rdata=0.
- TIMEOUT=8 with pready held 0:
  - After 8 ACCESS cycles psel drops; s_rsp_err=1.
  - The next queued request proceeds normally.
- rst asserted mid-ACCESS:
  - psel and penable go 0 in the same cycle; no s_rsp_valid.
  - After release, port 0 wins when ports 0 and 1 both request.

Source files
------------

// File: rtl/apb_master_arb_pkg.sv
// Shared definitions for the APB round-robin master: FSM encoding,
// pprot bit constants and width helpers used by the top and its arbiter.
package apb_master_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    // Timeout counter width; never narrower than one bit so TIMEOUT=0 still elaborates.
    function automatic int tmo_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting the search one
// port past the last accepted grant; pointer advances only on update.
module apb_rr_arb
    import apb_master_arb_pkg::*;
#(
    parameter int PORTS = 2,
    localparam int IDX_W = idx_w(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req_i,
    input  logic             upd_i,
    output logic [PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic             found;
    logic             hit;
    int               p;

    // Priority search from (last_q + 1) mod PORTS, wrapping once around.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        hit   = 1'b0;
        p     = 0;
        for (int k = 0; k < PORTS; k++) begin
            p        = (int'(last_q) + 1 + k) % PORTS;
            hit      = !found && req_i[p];
            gnt_o[p] = hit;
            idx_o    = hit ? IDX_W'(p) : idx_o;
            found    = found | hit;
        end
        last_d = upd_i ? idx_o : last_q;
    end

    // Pointer resets to the last port so port 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB4 master port between PORTS single-word request/response
// clients, with round-robin arbitration and an optional ACCESS timeout.
module apb_master_arb
    import apb_master_arb_pkg::*;
#(
    parameter int PORTS   = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS-1:0]        s_req_valid,
    output logic [PORTS-1:0]        s_req_ready,
    input  logic [PORTS*ADDR_W-1:0] s_req_addr,
    input  logic [PORTS-1:0]        s_req_write,
    input  logic [PORTS*DATA_W-1:0] s_req_wdata,
    input  logic [PORTS*STRB_W-1:0] s_req_strb,
    input  logic [PORTS*3-1:0]      s_req_prot,
    output logic [PORTS-1:0]        s_rsp_valid,
    output logic [DATA_W-1:0]       s_rsp_rdata,
    output logic                    s_rsp_err,
    output logic [ADDR_W-1:0]       m_apb_paddr,
    output logic [2:0]              m_apb_pprot,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [DATA_W-1:0]       m_apb_pwdata,
    output logic [STRB_W-1:0]       m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [DATA_W-1:0]       m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    localparam int IDX_W = idx_w(PORTS);
    localparam int CNT_W = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    apb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [PORTS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [PORTS-1:0]  gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              arb_upd_s;
    logic              sel_wr_s;
    logic              tmo_hit_s;

    apb_rr_arb #(.PORTS(PORTS)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (s_req_valid),
        .upd_i (arb_upd_s),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s)
    );

    assign s_req_ready = (state_q == ST_IDLE && !rst) ? gnt_s : '0;
    assign sel_wr_s    = s_req_write[gnt_idx_s];
    assign tmo_hit_s   = (TIMEOUT > 0) && (cnt_q == TMO_LAST);

    // Next-state and datapath: capture on accept, complete on pready or expiry.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        arb_upd_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|s_req_valid) begin
                    arb_upd_s = 1'b1;
                    grant_d   = gnt_idx_s;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = s_req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
                    pwrite_d  = sel_wr_s;
                    // APB4 reads carry no data or strobes.
                    pwdata_d  = sel_wr_s ? s_req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W] : '0;
                    pstrb_d   = sel_wr_s ? s_req_strb[int'(gnt_idx_s)*STRB_W +: STRB_W] : '0;
                    pprot_d   = s_req_prot[int'(gnt_idx_s)*3 +: 3];
                    state_d   = ST_SETUP;
                end else begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : m_apb_prdata;
                    rsp_err_d   = m_apb_pslverr;
                    rsp_valid_d = PORTS'(1'b1) << grant_q;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (tmo_hit_s) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = PORTS'(1'b1) << grant_q;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops psel/penable asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= 3'b000;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign m_apb_paddr   = paddr_q;
    assign m_apb_pprot   = pprot_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;
    assign s_rsp_valid   = rsp_valid_q;
    assign s_rsp_rdata   = rsp_rdata_q;
    assign s_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: two clients, a behavioural APB completer and a
// transaction-level model of arbitration order, latency and response content.
module tb_apb_master_arb;

    localparam int TMO = 8;
    localparam logic [15:0] ERR_ADDR  = 16'h00FF;
    localparam logic [15:0] HANG_ADDR = 16'h0BAD;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;
    typedef struct { int cyc; int port; req_t r; } acc_t;
    typedef struct { int cyc; logic [1:0] vec; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [15:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot; } apb_t;

    logic        clk;
    logic        rst;
    logic [1:0]  s_req_valid, s_req_ready, s_req_write, s_rsp_valid;
    logic [31:0] s_req_addr;
    logic [63:0] s_req_wdata;
    logic [7:0]  s_req_strb;
    logic [5:0]  s_req_prot;
    logic [31:0] s_rsp_rdata, m_apb_pwdata, m_apb_prdata;
    logic        s_rsp_err, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pready, m_apb_pslverr;
    logic [15:0] m_apb_paddr;
    logic [2:0]  m_apb_pprot;
    logic [3:0]  m_apb_pstrb;

    req_t        cur [2];
    logic [1:0]  drv_valid;
    logic [1:0]  acc_seen;
    req_t        pend0[$], pend1[$];
    acc_t        acc_log[$];
    rsp_t        rsp_log[$];
    apb_t        apb_log[$];
    int          cyc, waits_cfg, model_last, checks, errors;
    int          rem [2];
    int          rd_viol, stab_viol, rdy_viol;
    apb_t        setup_snap;

    apb_master_arb #(.PORTS(2), .DATA_W(32), .ADDR_W(16), .STRB_W(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_write(s_req_write), .s_req_wdata(s_req_wdata), .s_req_strb(s_req_strb),
        .s_req_prot(s_req_prot), .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err), .m_apb_paddr(m_apb_paddr), .m_apb_pprot(m_apb_pprot),
        .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
        .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb), .m_apb_pready(m_apb_pready),
        .m_apb_prdata(m_apb_prdata), .m_apb_pslverr(m_apb_pslverr)
    );

    assign s_req_valid = drv_valid;
    assign s_req_write = {cur[1].wr, cur[0].wr};
    assign s_req_addr  = {cur[1].addr, cur[0].addr};
    assign s_req_wdata = {cur[1].data, cur[0].data};
    assign s_req_strb  = {cur[1].strb, cur[0].strb};
    assign s_req_prot  = {cur[1].prot, cur[0].prot};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] comp_rdata(input logic [15:0] a);
        if (a == 16'h0020) return 32'h12345678;
        else return {a ^ 16'hA5A5, a};
    endfunction

    function automatic req_t mk(input logic wr, input logic [15:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [2:0] p);
        req_t r;
        r.wr = wr; r.addr = a; r.data = d; r.strb = s; r.prot = p;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input req_t r);
        rem[port]++;
        if (port == 0) pend0.push_back(r);
        else pend1.push_back(r);
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_log.size() < n && k < 100) begin
            @(posedge clk); #2; k++;
        end
        chk("accept_seen", 64'(acc_log.size() >= n), 64'(1));
    endtask

    // Compare n transfers against the model: rr order, latency, response, APB fields.
    task automatic check_batch(input int n, input int waits);
        int k = 0;
        int prev_rsp = 0;
        int exp_port;
        bit hang;
        acc_t a; rsp_t s; apb_t t;
        while (rsp_log.size() < n && k < 600) begin
            @(posedge clk); #2; k++;
        end
        chk("batch_complete", 64'(rsp_log.size() >= n), 64'(1));
        if (rsp_log.size() < n || acc_log.size() < n) begin
            acc_log.delete(); rsp_log.delete(); apb_log.delete(); rem = '{0, 0};
            return;
        end
        for (int i = 0; i < n; i++) begin
            a = acc_log.pop_front();
            s = rsp_log.pop_front();
            exp_port = -1;
            for (int j = 1; j <= 2; j++)
                if (exp_port < 0 && rem[(model_last + j) % 2] > 0) exp_port = (model_last + j) % 2;
            chk("grant_port", 64'(a.port), 64'(exp_port));
            if (exp_port >= 0) begin model_last = exp_port; rem[exp_port]--; end
            if (i > 0) chk("accept_spacing", 64'(a.cyc), 64'(prev_rsp));
            hang = (a.r.addr == HANG_ADDR);
            chk("rsp_latency", 64'(s.cyc - a.cyc), 64'(hang ? 2 + TMO : 3 + waits));
            chk("rsp_port", 64'(s.vec), 64'(2'b01 << a.port));
            chk("rsp_err", 64'(s.err), 64'(hang || a.r.addr == ERR_ADDR));
            chk("rsp_rdata", 64'(s.rdata), 64'((hang || a.r.wr) ? 32'h0 : comp_rdata(a.r.addr)));
            if (!hang) begin
                chk("apb_seen", 64'(apb_log.size() > 0), 64'(1));
                if (apb_log.size() > 0) begin
                    t = apb_log.pop_front();
                    chk("apb_addr", 64'(t.addr), 64'(a.r.addr));
                    chk("apb_write", 64'(t.wr), 64'(a.r.wr));
                    chk("apb_wdata", 64'(t.wdata), 64'(a.r.wr ? a.r.data : 32'h0));
                    chk("apb_strb", 64'(t.strb), 64'(a.r.wr ? a.r.strb : 4'h0));
                    chk("apb_prot", 64'(t.prot), 64'(a.r.prot));
                end
            end
            prev_rsp = s.cyc;
        end
    endtask

    // Client driver: holds each request valid until it is accepted.
    initial begin
        drv_valid = 2'b00;
        cur[0] = mk(1'b0, 16'h0, 32'h0, 4'h0, 3'b000);
        cur[1] = mk(1'b0, 16'h0, 32'h0, 4'h0, 3'b000);
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (drv_valid[p] && acc_seen[p]) drv_valid[p] = 1'b0;
                if (!drv_valid[p] && p == 0 && pend0.size() > 0) begin cur[0] = pend0.pop_front(); drv_valid[0] = 1'b1; end
                if (!drv_valid[p] && p == 1 && pend1.size() > 0) begin cur[1] = pend1.pop_front(); drv_valid[1] = 1'b1; end
            end
        end
    end

    // Monitor: timestamps accepts and responses on the falling edge.
    initial begin
        cyc = 0; acc_seen = 2'b00; rdy_viol = 0;
        forever begin
            @(negedge clk);
            cyc++;
            acc_seen = rst ? 2'b00 : (s_req_valid & s_req_ready);
            if ($countones(s_req_ready) > 1) rdy_viol++;
            for (int p = 0; p < 2; p++)
                if (acc_seen[p]) acc_log.push_back('{cyc, p, cur[p]});
            if (!rst && |s_rsp_valid) rsp_log.push_back('{cyc, s_rsp_valid, s_rsp_rdata, s_rsp_err});
        end
    end

    // Completer: waits_cfg wait states, never ready for HANG_ADDR, error on ERR_ADDR.
    initial begin
        int acc_cnt = 0;
        m_apb_pready = 1'b0; m_apb_prdata = 32'h0; m_apb_pslverr = 1'b0;
        rd_viol = 0; stab_viol = 0;
        setup_snap = '{16'h0, 1'b0, 32'h0, 4'h0, 3'b000};
        forever begin
            @(negedge clk);
            if (m_apb_psel && !m_apb_pwrite && (m_apb_pwdata != 32'h0 || m_apb_pstrb != 4'h0)) rd_viol++;
            if (m_apb_psel && m_apb_penable) begin
                acc_cnt++;
                if (setup_snap != '{m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot}) stab_viol++;
                if (m_apb_paddr != HANG_ADDR && acc_cnt > waits_cfg) begin
                    m_apb_pready  = 1'b1;
                    m_apb_prdata  = m_apb_pwrite ? $urandom : comp_rdata(m_apb_paddr);
                    m_apb_pslverr = (m_apb_paddr == ERR_ADDR);
                    apb_log.push_back('{m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot});
                end else begin
                    m_apb_pready  = 1'b0;
                    m_apb_prdata  = $urandom;
                    m_apb_pslverr = 1'($urandom);
                end
            end else begin
                acc_cnt = 0;
                m_apb_pready = 1'b0; m_apb_prdata = 32'h0; m_apb_pslverr = 1'b0;
                if (m_apb_psel) setup_snap = '{m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrsp, n0, n1;
        checks = 0; errors = 0; waits_cfg = 0; model_last = 1; rem = '{0, 0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_psel", 64'(m_apb_psel), 64'(0));
        chk("rst_penable", 64'(m_apb_penable), 64'(0));
        chk("rst_paddr", 64'(m_apb_paddr), 64'(0));
        chk("rst_pwrite", 64'(m_apb_pwrite), 64'(0));
        chk("rst_pwdata", 64'(m_apb_pwdata), 64'(0));
        chk("rst_pstrb", 64'(m_apb_pstrb), 64'(0));
        chk("rst_pprot", 64'(m_apb_pprot), 64'(0));
        chk("rst_ready", 64'(s_req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(s_rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(s_rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(s_rsp_err), 64'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Port 0 write, zero-wait: psel then penable phasing.
        push(0, mk(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b010));
        wait_acc(1);
        chk("setup_psel", 64'(m_apb_psel), 64'(1));
        chk("setup_penable", 64'(m_apb_penable), 64'(0));
        @(posedge clk); #2;
        chk("access_psel", 64'(m_apb_psel), 64'(1));
        chk("access_penable", 64'(m_apb_penable), 64'(1));
        check_batch(1, 0);

        // Port 1 read with two wait states.
        waits_cfg = 2;
        push(1, mk(1'b0, 16'h0020, 32'hCAFEF00D, 4'hA, 3'b001));
        check_batch(1, 2);

        // Both ports, four transfers each, back to back.
        waits_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            push(0, mk(1'(i), 16'(16'h0100 + 16'(i * 4)), $urandom, 4'($urandom), 3'($urandom)));
            push(1, mk(1'(~i), 16'(16'h0200 + 16'(i * 4)), $urandom, 4'($urandom), 3'($urandom)));
        end
        check_batch(8, 0);

        // Slave error on write.
        push(0, mk(1'b1, ERR_ADDR, 32'h0BADF00D, 4'h3, 3'b000));
        check_batch(1, 0);

        // Hung completer times out; the queued request then completes normally.
        push(1, mk(1'b0, HANG_ADDR, 32'h11111111, 4'hF, 3'b100));
        push(0, mk(1'b0, 16'h0030, 32'h0, 4'h0, 3'b010));
        check_batch(2, 0);

        // pready in the expiry cycle wins, pslverr honoured.
        waits_cfg = TMO - 1;
        push(0, mk(1'b0, ERR_ADDR, 32'h0, 4'h0, 3'b000));
        push(1, mk(1'b0, 16'h0040, 32'h0, 4'h0, 3'b000));
        check_batch(2, TMO - 1);

        // Reset during ACCESS: immediate deassert, no response, pointer back to port 0.
        waits_cfg = 5;
        push(0, mk(1'b0, 16'h0050, 32'h0, 4'h0, 3'b000));
        wait_acc(1);
        @(posedge clk); #2;
        chk("pre_rst_penable", 64'(m_apb_penable), 64'(1));
        nrsp = rsp_log.size();
        rst = 1'b1;
        #1;
        chk("rst_async_psel", 64'(m_apb_psel), 64'(0));
        chk("rst_async_penable", 64'(m_apb_penable), 64'(0));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_no_response", 64'(rsp_log.size()), 64'(nrsp));
        acc_log.delete(); apb_log.delete(); rem = '{0, 0}; model_last = 1;
        waits_cfg = 0;
        push(1, mk(1'b1, 16'h0060, 32'h600D600D, 4'hC, 3'b000));
        push(0, mk(1'b1, 16'h0070, 32'h700D700D, 4'h1, 3'b000));
        check_batch(2, 0);

        // Randomized batches against the model.
        for (int b = 0; b < 6; b++) begin
            waits_cfg = $urandom_range(0, 3);
            n0 = $urandom_range(1, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0 + n1; i++)
                push((i < n0) ? 0 : 1,
                     mk(1'($urandom), ($urandom_range(0, 5) == 0) ? ERR_ADDR : (16'($urandom) & 16'hFFFE),
                        $urandom, 4'($urandom), 3'($urandom)));
            check_batch(n0 + n1, waits_cfg);
        end

        chk("read_data_strb_zero", 64'(rd_viol), 64'(0));
        chk("access_fields_stable", 64'(stab_viol), 64'(0));
        chk("ready_onehot", 64'(rdy_viol), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
